// File: rtl/bus_timer_responder.sv
// rtl/bus_timer_responder.sv - CPU-bus mapped 16-bit down-counting timer with IRQ
//
// Ports:
//   CLK    system clock, all state changes on the rising edge
//   RST    synchronous active-high reset
//   PHI2   CPU phase-2 clock, sampled as a level on CLK
//   CS     externally decoded chip select
//   A      register address (0 TLO, 1 THI, 2 CTRL, 3 STAT)
//   RW     1 = CPU read, 0 = CPU write
//   DI     CPU write data, taken at the PHI2 falling edge
//   DO     read data, held after the access ends
//   DOE    read-data drive enable, high for the PHI2-high part of a read
//   IRQ_N  active-low interrupt request, ~(FLAG & IEN)
module bus_timer_responder (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PHI2,
    input  logic       CS,
    input  logic [1:0] A,
    input  logic       RW,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       DOE,
    output logic       IRQ_N
);

    localparam logic [0:0] BUS_IDLE    = 1'b0;
    localparam logic [0:0] BUS_ACCESS  = 1'b1;
    localparam logic [0:0] TMR_STOPPED = 1'b0;
    localparam logic [0:0] TMR_RUNNING = 1'b1;

    logic        phi2_q,  phi2_d;
    logic [0:0]  bus_q,   bus_d;
    logic [1:0]  addr_q,  addr_d;
    logic        rw_q,    rw_d;
    logic [7:0]  do_q,    do_d;
    logic        doe_q,   doe_d;
    logic [15:0] count_q, count_d;
    logic [15:0] latch_q, latch_d;
    logic        ien_q,   ien_d;
    logic        cont_q,  cont_d;
    logic        flag_q,  flag_d;
    logic [0:0]  tmr_q,   tmr_d;
    logic        irq_n_q, irq_n_d;

    logic        rise;
    logic        fall;
    logic        expire;
    logic        status_clear;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_data;

    assign rise = PHI2 & ~phi2_q;
    assign fall = ~PHI2 & phi2_q;

    // The address comes straight from the bus on the rise edge and from the
    // captured copy for the rest of the access.
    assign rd_sel = (bus_q == BUS_IDLE) ? A : addr_q;

    always_comb begin
        rd_data = 8'h00;
        case (rd_sel)
            2'd0:    rd_data = count_q[7:0];
            2'd1:    rd_data = count_q[15:8];
            2'd2:    rd_data = {6'b0, cont_q, ien_q};
            default: rd_data = {7'b0, flag_q};
        endcase
    end

    assign expire = fall && (tmr_q == TMR_RUNNING) && (count_q == 16'h0000);

    always_comb begin
        phi2_d       = PHI2;
        bus_d        = bus_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        do_d         = do_q;
        doe_d        = doe_q;
        count_d      = count_q;
        latch_d      = latch_q;
        ien_d        = ien_q;
        cont_d       = cont_q;
        flag_d       = flag_q;
        tmr_d        = tmr_q;
        status_clear = 1'b0;

        // Timer step: once per CPU cycle, on the PHI2 falling edge.
        if (fall && (tmr_q == TMR_RUNNING)) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'd1;
            end else begin
                flag_d = 1'b1;
                if (cont_q) begin
                    count_d = latch_q;
                end else begin
                    tmr_d = TMR_STOPPED;
                end
            end
        end

        // Bus side. Commits below are placed after the timer step so a THI
        // write overrides the timer's count/FLAG update on the same edge.
        case (bus_q)
            BUS_IDLE: begin
                if (rise && CS) begin
                    bus_d  = BUS_ACCESS;
                    addr_d = A;
                    rw_d   = RW;
                    doe_d  = RW;
                    if (RW) begin
                        do_d = rd_data;
                    end
                end
            end
            default: begin
                if (fall) begin
                    bus_d = BUS_IDLE;
                    doe_d = 1'b0;
                    if (rw_q) begin
                        status_clear = (addr_q == 2'd3);
                    end else begin
                        case (addr_q)
                            2'd0: latch_d[7:0] = DI;
                            2'd1: begin
                                latch_d[15:8] = DI;
                                count_d       = {DI, latch_q[7:0]};
                                tmr_d         = TMR_RUNNING;
                                flag_d        = 1'b0;
                            end
                            2'd2: begin
                                ien_d  = DI[0];
                                cont_d = DI[1];
                            end
                            default: status_clear = DI[0];
                        endcase
                    end
                    // A coincident expiry wins over a status clear.
                    if (status_clear && !expire) begin
                        flag_d = 1'b0;
                    end
                end else if (rw_q) begin
                    do_d = rd_data;
                end
            end
        endcase

        irq_n_d = ~(flag_d & ien_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phi2_q  <= 1'b0;
            bus_q   <= BUS_IDLE;
            addr_q  <= 2'd0;
            rw_q    <= 1'b0;
            do_q    <= 8'h00;
            doe_q   <= 1'b0;
            count_q <= 16'h0000;
            latch_q <= 16'h0000;
            ien_q   <= 1'b0;
            cont_q  <= 1'b0;
            flag_q  <= 1'b0;
            tmr_q   <= TMR_STOPPED;
            irq_n_q <= 1'b1;
        end else begin
            phi2_q  <= phi2_d;
            bus_q   <= bus_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            do_q    <= do_d;
            doe_q   <= doe_d;
            count_q <= count_d;
            latch_q <= latch_d;
            ien_q   <= ien_d;
            cont_q  <= cont_d;
            flag_q  <= flag_d;
            tmr_q   <= tmr_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign DO    = do_q;
    assign DOE   = doe_q;
    assign IRQ_N = irq_n_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// tb/tb_bus_timer_responder.sv - bench for bus_timer_responder
module tb_bus_timer_responder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PHI2;
    logic       CS;
    logic [1:0] A;
    logic       RW;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       DOE;
    logic       IRQ_N;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    bus_timer_responder dut (
        .CLK   (CLK),
        .RST   (RST),
        .PHI2  (PHI2),
        .CS    (CS),
        .A     (A),
        .RW    (RW),
        .DI    (DI),
        .DO    (DO),
        .DOE   (DOE),
        .IRQ_N (IRQ_N)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: visible registers plus the one pending CPU access.
    typedef struct packed {
        logic        phi2;
        logic        acc;
        logic        rw;
        logic [1:0]  addr;
        logic [7:0]  dout;
        logic        doe;
        logic [15:0] count;
        logic [15:0] latch;
        logic        ien;
        logic        cont;
        logic        flag;
        logic        run;
    } mstate_t;

    mstate_t m;
    logic    m_valid = 1'b0;

    function automatic logic [7:0] mreg(input mstate_t s, input logic [1:0] a);
        case (a)
            2'd0:    return s.count[7:0];
            2'd1:    return s.count[15:8];
            2'd2:    return {6'b0, s.cont, s.ien};
            default: return {7'b0, s.flag};
        endcase
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic rst, input logic phi2,
                                     input logic cs, input logic [1:0] a, input logic rw,
                                     input logic [7:0] di);
        mstate_t n;
        logic    expired;
        logic    clr;
        n = s;
        if (rst) return '0;
        if (!phi2 && s.phi2) begin
            expired = s.run && (s.count == 16'd0);
            if (s.run) begin
                if (s.count != 16'd0) n.count = s.count - 16'd1;
                else begin
                    n.flag = 1'b1;
                    if (s.cont) n.count = s.latch;
                    else        n.run   = 1'b0;
                end
            end
            if (s.acc) begin
                clr = (s.addr == 2'd3) && (s.rw || di[0]);
                if (clr && !expired) n.flag = 1'b0;
                if (!s.rw) begin
                    if (s.addr == 2'd0) n.latch[7:0] = di;
                    if (s.addr == 2'd1) begin
                        n.latch[15:8] = di;
                        n.count       = {di, s.latch[7:0]};
                        n.run         = 1'b1;
                        n.flag        = 1'b0;
                    end
                    if (s.addr == 2'd2) begin
                        n.ien  = di[0];
                        n.cont = di[1];
                    end
                end
            end
            n.acc = 1'b0;
            n.doe = 1'b0;
        end else if (phi2 && !s.phi2 && cs) begin
            // Registers only move on falling edges, so the value seen at the
            // rise is what the whole access returns.
            n.acc  = 1'b1;
            n.addr = a;
            n.rw   = rw;
            n.doe  = rw;
            if (rw) n.dout = mreg(s, a);
        end
        n.phi2 = phi2;
        return n;
    endfunction

    always @(posedge CLK) begin
        m       <= step(m, RST, PHI2, CS, A, RW, DI);
        m_valid <= 1'b1;
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cyc_doe",   16'(DOE),   16'(m.doe));
            chk("cyc_do",    16'(DO),    16'(m.dout));
            chk("cyc_irq_n", 16'(IRQ_N), 16'(!(m.flag && m.ien)));
        end
    end

    // One CPU cycle; called and returning at posedge+1 with PHI2 low.
    task automatic cpu(input logic cs, input logic [1:0] a, input logic rw, input logic [7:0] di,
                       input int hi, input int lo, input logic cs_late,
                       output logic [7:0] rd, output logic rdoe);
        CS   = cs_late ? 1'b0 : cs;
        A    = a;
        RW   = rw;
        DI   = di;
        PHI2 = 1'b1;
        @(posedge CLK); #1;
        if (cs_late) CS = 1'b1;
        repeat (hi - 1) begin @(posedge CLK); #1; end
        rd   = DO;
        rdoe = DOE;
        PHI2 = 1'b0;
        @(posedge CLK); #1;
        CS = 1'b0;
        A  = 2'($urandom);
        RW = 1'($urandom);
        DI = 8'($urandom);
        repeat (lo - 1) begin @(posedge CLK); #1; end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] di);
        logic [7:0] d;
        logic       e;
        cpu(1'b1, a, 1'b0, di, 3, 2, 1'b0, d, e);
    endtask

    task automatic rdr(input logic [1:0] a, output logic [7:0] v);
        logic e;
        cpu(1'b1, a, 1'b1, 8'h00, 3, 2, 1'b0, v, e);
    endtask

    task automatic idle();
        logic [7:0] d;
        logic       e;
        cpu(1'b0, 2'd0, 1'b1, 8'h00, 3, 2, 1'b0, d, e);
    endtask

    initial begin
        logic [7:0] v;
        logic       e;
        RST = 1'b1; PHI2 = 1'b0; CS = 1'b0; A = 2'd0; RW = 1'b0; DI = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_doe", 16'(DOE), 16'h0);
        chk("rst_do", 16'(DO), 16'h00);
        chk("rst_irq_n", 16'(IRQ_N), 16'h1);

        // One-shot: start value 3 expires on the 4th fall edge.
        wr(2'd0, 8'h03); wr(2'd2, 8'h01); wr(2'd1, 8'h00);
        rdr(2'd0, v); chk("os_cnt3", 16'(v), 16'h03);
        rdr(2'd0, v); chk("os_cnt2", 16'(v), 16'h02);
        rdr(2'd0, v); chk("os_cnt1", 16'(v), 16'h01);
        chk("os_irq_pre", 16'(IRQ_N), 16'h1);
        rdr(2'd0, v); chk("os_cnt0", 16'(v), 16'h00);
        chk("os_irq_exp", 16'(IRQ_N), 16'h0);
        rdr(2'd0, v); chk("os_stop_lo", 16'(v), 16'h00);
        rdr(2'd1, v); chk("os_stop_hi", 16'(v), 16'h00);
        rdr(2'd2, v); chk("os_ctrl", 16'(v), 16'h01);

        // Status read returns the pre-clear value and clears FLAG.
        cpu(1'b1, 2'd3, 1'b1, 8'h00, 3, 2, 1'b0, v, e);
        chk("stat_do", 16'(v), 16'h01);
        chk("stat_doe", 16'(e), 16'h1);
        chk("stat_irq", 16'(IRQ_N), 16'h1);
        rdr(2'd3, v); chk("stat_cleared", 16'(v), 16'h00);

        // Continuous mode with latch 1: count 1,0,1,0.
        wr(2'd2, 8'h03); wr(2'd0, 8'h01); wr(2'd1, 8'h00);
        rdr(2'd0, v); chk("cont_c1a", 16'(v), 16'h01);
        chk("cont_irq_a", 16'(IRQ_N), 16'h1);
        rdr(2'd0, v); chk("cont_c0a", 16'(v), 16'h00);
        chk("cont_irq_b", 16'(IRQ_N), 16'h0);
        rdr(2'd0, v); chk("cont_c1b", 16'(v), 16'h01);
        rdr(2'd0, v); chk("cont_c0b", 16'(v), 16'h00);

        // THI write on the expiry edge wins.
        wr(2'd1, 8'h00);
        chk("thi_irq0", 16'(IRQ_N), 16'h1);
        idle();
        wr(2'd1, 8'h05);
        chk("thi_exp_irq", 16'(IRQ_N), 16'h1);
        rdr(2'd0, v); chk("thi_exp_lo", 16'(v), 16'h01);
        rdr(2'd1, v); chk("thi_exp_hi", 16'(v), 16'h05);

        // Status-clear read on the expiry edge: FLAG stays set.
        wr(2'd1, 8'h00);
        idle();
        rdr(2'd3, v); chk("clr_exp_rd", 16'(v), 16'h00);
        chk("clr_exp_irq", 16'(IRQ_N), 16'h0);
        rdr(2'd3, v); chk("clr_after_rd", 16'(v), 16'h01);
        chk("clr_after_irq", 16'(IRQ_N), 16'h1);
        wr(2'd3, 8'h01);
        chk("wclr_exp_irq", 16'(IRQ_N), 16'h0);

        // Reset in the middle of a CTRL write access.
        CS = 1'b1; A = 2'd2; RW = 1'b0; DI = 8'h03; PHI2 = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1; CS = 1'b0;
        @(posedge CLK); #1;
        chk("rstacc_doe", 16'(DOE), 16'h0);
        chk("rstacc_irq", 16'(IRQ_N), 16'h1);
        RST = 1'b0;
        @(posedge CLK); #1;
        PHI2 = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rdr(2'd2, v); chk("rstacc_ctrl", 16'(v), 16'h00);
        rdr(2'd0, v); chk("rstacc_cnt", 16'(v), 16'h00);

        // CS low at the rise: ignored even if CS rises mid-PHI2.
        wr(2'd2, 8'h03);
        cpu(1'b1, 2'd2, 1'b0, 8'h00, 3, 2, 1'b1, v, e);
        chk("latecs_wdoe", 16'(e), 16'h0);
        cpu(1'b1, 2'd3, 1'b1, 8'h00, 3, 2, 1'b1, v, e);
        chk("latecs_rdoe", 16'(e), 16'h0);
        rdr(2'd2, v); chk("latecs_ctrl", 16'(v), 16'h03);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
            end else begin
                logic [1:0] ra;
                logic [7:0] rdi;
                ra  = 2'($urandom);
                rdi = (ra == 2'd1) ? 8'($urandom_range(0, 1)) : 8'($urandom);
                cpu(($urandom_range(0, 3) != 0), ra, 1'($urandom), rdi,
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    ($urandom_range(0, 7) == 0), v, e);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_timer_responder.md
BUS_TIMER_RESPONDER -- requirements
Module: bus_timer_responder

Interface
REQ-001 SHALL have these ports, in this order:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- PHI2  input  1  CPU phase-2 clock from the clock generator, sampled as a level on CLK.
- CS  input  1  chip select, already decoded externally.
- A  input  2  register address.
- RW  input  1  1 = CPU read, 0 = CPU write.
- DI  input  8  write data from the CPU.
- DO  output  8  read data to the CPU.
- DOE  output  1  read-data drive enable.
- IRQ_N  output  1  active-low interrupt request.
REQ-002 SHALL use one clock with synchronous, active-high reset, as fixed by the Already-decided line.
REQ-003 SHALL implement this register map:
- 0: TLO, read count[7:0], write latch[7:0].
- 1: THI, read count[15:8], write latch[15:8] plus start.
- 2: CTRL, bit0 IEN, bit1 CONT, other bits read 0.
- 3: STAT, bit0 FLAG, other bits read 0.

Function
REQ-004 SHALL keep phi2_q, the value of PHI2 registered on the previous CLK edge.
- rise = PHI2 & ~phi2_q.
- fall = ~PHI2 & phi2_q.
REQ-005 SHALL, on any edge where rise is true and CS = 1, capture A and RW and enter bus state ACCESS; otherwise the bus state SHALL stay IDLE.
REQ-006 SHALL, for a read in ACCESS, assert DOE = 1 and drive DO with the addressed register, both registered from the rise edge; DO SHALL track the register value while in ACCESS.
REQ-007 SHALL, on the fall edge out of ACCESS:
- deassert DOE, hold DO at its last value, and return to IDLE;
- commit any side effect using DI sampled at that fall edge.
REQ-008 SHALL apply these write effects:
- A = 0: latch[7:0] <= DI.
- A = 1: latch[15:8] <= DI; count <= {DI, latch[7:0]}; timer goes to RUNNING; FLAG cleared.
- A = 2: IEN <= DI[0]; CONT <= DI[1].
- A = 3: DI[0] = 1 clears FLAG.
REQ-009 SHALL clear FLAG on the fall edge of a read with A = 3; the value returned by that read is the pre-clear value.
REQ-010 SHALL implement the timer with states STOPPED and RUNNING; it changes only on fall edges, once per CPU cycle.
REQ-011 SHALL, while RUNNING, do the following at each fall edge:
- count != 0: count <= count - 1.
- count == 0: FLAG <= 1; if CONT = 1, count <= latch and stay RUNNING; if CONT = 0, go to STOPPED with count held at 0.
REQ-012 SHALL use 16-bit count arithmetic with no wrap below 0, so a start value N produces expiry after N+1 fall edges.
REQ-013 SHALL give a write to A = 1 on the same fall edge as an expiry priority: the reload is taken from the write and FLAG = 0.
REQ-014 SHALL give set priority when a status clear (read A = 3, or write A = 3 with DI[0] = 1) coincides with an expiry: FLAG = 1.
REQ-015 SHALL drive IRQ_N = ~(FLAG & IEN) as a registered output, updated on the same edge as FLAG or IEN.
REQ-016 SHALL ignore CS, A, RW and DI outside ACCESS, and SHALL ignore a rise edge with CS = 0.
REQ-017 SHALL treat the timer and bus state machines as independent, so a timer step and a bus commit may occur on the same edge.

Reset
REQ-018 SHALL, with RST = 1, set the following on the next CLK edge, overriding all other activity:
- count = 0, latch = 0, IEN = 0, CONT = 0, FLAG = 0;
- timer STOPPED, bus IDLE;
- phi2_q = 0, DOE = 0, DO = 0x00, IRQ_N = 1.
REQ-019 SHALL discard an access in progress when reset is applied mid-ACCESS: no commit, and DOE = 0.
REQ-020 SHALL consider a PHI2 that is already high when RST deasserts as a rise edge only if phi2_q = 0, which is the reset value.

Verification
REQ-021 Write sequence: write TLO = 0x03, write CTRL = 0x01, write THI = 0x00.
- Required: expiry (FLAG = 1) on the 4th subsequent fall edge.
- Required: IRQ_N = 0, timer STOPPED, count = 0.
REQ-022 CONT = 1, latch = 0x0001, started.
- Required: FLAG sets every 2 fall edges.
- Required: count sequence 1, 0, 1, 0...
REQ-023 Read A = 3 with FLAG = 1.
- Required: DO = 0x01 with DOE = 1 during PHI2 high.
- Required: FLAG = 0 and IRQ_N = 1 after the fall edge.
REQ-024 Write THI on the expiry edge.
- Required: FLAG = 0 and count = new value.
- Required: a status-clear read on the expiry edge leaves FLAG = 1.
REQ-025 Assert RST during a write ACCESS to A = 2 with DI = 0x03.
- Required: IEN = 0, CONT = 0, DOE = 0.
- Required: no commit on the following fall edge.
REQ-026 Access with CS = 0 at the rise edge.
- Required: DOE stays 0.
- Required: no register change even if CS rises mid-PHI2.
